// File: rtl/wb_serial_divider_if.sv
// Wishbone classic slave bus bundle for the serial divider.
interface wb_serial_divider_if #(
    parameter int WBW = 32
);
    logic             wbs_stb_i;
    logic             wbs_cyc_i;
    logic             wbs_we_i;
    logic [WBW/8-1:0] wbs_sel_i;
    logic [WBW-1:0]   wbs_adr_i;
    logic [WBW-1:0]   wbs_dat_i;
    logic             wbs_ack_o;
    logic [WBW-1:0]   wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_serial_divider.sv
// Wishbone-mapped restoring divider: one quotient bit per cycle, with a
// single sign-fixup cycle and fast paths for divide-by-zero and overflow.
module wb_serial_divider #(
    parameter int WBW     = 32,
    parameter int XLEN    = 32,
    parameter int LAW     = 32,
    parameter int BLINK_W = 24
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    wb_serial_divider_if.slave  wb,
    output logic                irq_o,
    output logic                start_o,
    output logic                fini_o,
    output logic                busy_o,
    output logic [LAW-1:0]      la_data_o,
    output logic                hw_blinky_o,
    output logic                sw_blinky_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state_q, state_d;

    // Bus-visible registers
    logic [XLEN-1:0]    dividend_q, divisor_q;
    logic               signed_q, irq_en_q, sw_blink_q;
    logic               done_q, dbz_q, ovf_q;
    logic [XLEN-1:0]    quotient_q, remainder_q;
    logic               ack_q;
    logic [WBW-1:0]     dat_q;
    logic               start_q, fini_q;
    logic [BLINK_W-1:0] blink_q;

    // Working registers of the running operation
    logic [XLEN-1:0]    w_raw;   // original dividend, needed by the fast paths
    logic [XLEN-1:0]    w_num;   // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_den;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_neg_q, w_neg_r, w_dbz, w_ovf;

    // Bus decode
    logic            req, wr, rd;
    logic [2:0]      reg_idx;
    logic [XLEN-1:0] wdata;
    logic [WBW-1:0]  rdata;
    logic            wr_dividend, wr_divisor, wr_ctrl, wr_status;

    assign req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign wr      = req & wb.wbs_we_i;
    assign rd      = req & ~wb.wbs_we_i;
    assign reg_idx = wb.wbs_adr_i[4:2];
    assign wdata   = wb.wbs_dat_i[XLEN-1:0];

    assign wr_dividend = wr && (reg_idx == 3'd0);
    assign wr_divisor  = wr && (reg_idx == 3'd1);
    assign wr_ctrl     = wr && (reg_idx == 3'd2);
    assign wr_status   = wr && (reg_idx == 3'd3);

    // Byte selects and unused address/data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i, wb.wbs_dat_i};

    // Start handling: mode comes from the CTRL word being written
    logic            start_go, sgn_new, sp_dbz, sp_ovf;
    logic            fix_exit;

    assign start_go = wr_ctrl && wdata[0] && (state_q == IDLE);
    assign sgn_new  = wdata[1];
    assign sp_dbz   = (divisor_q == '0);
    assign sp_ovf   = sgn_new && (dividend_q == MOST_NEG) && (divisor_q == '1);
    assign fix_exit = (state_q == FIX);

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    // One restoring step: shift in next dividend bit, subtract if it fits
    logic [XLEN:0]   shifted, diff;
    assign shifted = {w_rem, w_num[XLEN-1]};
    assign diff    = shifted - {1'b0, w_den};

    // Final result selection during the fixup cycle
    logic [XLEN-1:0] q_fix, r_fix;
    always_comb begin
        q_fix = w_neg_q ? -w_num : w_num;
        r_fix = w_neg_r ? -w_rem : w_rem;
        if (w_dbz) begin
            q_fix = '1;
            r_fix = w_raw;
        end else if (w_ovf) begin
            q_fix = w_raw;
            r_fix = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next state: fast paths skip CALC entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = (sp_dbz || sp_ovf) ? FIX : CALC;
            CALC:    if (w_cnt == LAST_STEP) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working datapath: latch operands on start, iterate while in CALC
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            w_raw   <= '0;
            w_num   <= '0;
            w_rem   <= '0;
            w_den   <= '0;
            w_cnt   <= '0;
            w_neg_q <= 1'b0;
            w_neg_r <= 1'b0;
            w_dbz   <= 1'b0;
            w_ovf   <= 1'b0;
        end else if (start_go) begin
            w_raw   <= dividend_q;
            w_num   <= mag(dividend_q, sgn_new);
            w_den   <= mag(divisor_q, sgn_new);
            w_rem   <= '0;
            w_cnt   <= '0;
            w_neg_q <= sgn_new && (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]);
            w_neg_r <= sgn_new && dividend_q[XLEN-1];
            w_dbz   <= sp_dbz;
            w_ovf   <= !sp_dbz && sp_ovf;
        end else if (state_q == CALC) begin
            w_cnt <= w_cnt + CNT_W'(1);
            if (!diff[XLEN]) begin
                w_rem <= diff[XLEN-1:0];
                w_num <= {w_num[XLEN-2:0], 1'b1};
            end else begin
                w_rem <= shifted[XLEN-1:0];
                w_num <= {w_num[XLEN-2:0], 1'b0};
            end
        end
    end

    // Operand and control registers; CTRL mode bits update even while busy
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            sw_blink_q <= 1'b0;
        end else begin
            if (wr_dividend) dividend_q <= wdata;
            if (wr_divisor)  divisor_q  <= wdata;
            if (wr_ctrl) begin
                signed_q   <= wdata[1];
                irq_en_q   <= wdata[2];
                sw_blink_q <= wdata[3];
            end
        end
    end

    // Results and status; completion beats a same-cycle W1C of done
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (fix_exit) begin
            quotient_q  <= q_fix;
            remainder_q <= r_fix;
            done_q      <= 1'b1;
            dbz_q       <= w_dbz;
            ovf_q       <= w_ovf;
        end else if (start_go) begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (wr_status && wdata[1]) begin
            done_q <= 1'b0;
        end
    end

    // Single-cycle event pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            start_q <= 1'b0;
            fini_q  <= 1'b0;
        end else begin
            start_q <= start_go;
            fini_q  <= fix_exit;
        end
    end

    // Read mux; narrow registers zero-extend to the bus width
    always_comb begin
        rdata = '0;
        case (reg_idx)
            3'd0:    rdata = WBW'(dividend_q);
            3'd1:    rdata = WBW'(divisor_q);
            3'd2:    rdata = WBW'({sw_blink_q, irq_en_q, signed_q, 1'b0});
            3'd3:    rdata = WBW'({ovf_q, dbz_q, done_q, busy_o});
            3'd4:    rdata = WBW'(quotient_q);
            3'd5:    rdata = WBW'(remainder_q);
            default: rdata = '0;
        endcase
    end

    // Registered ack and read data; ack low forces a gap between requests
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= rd ? rdata : '0;
        end
    end

    // Free-running blink counter
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) blink_q <= '0;
        else           blink_q <= blink_q + BLINK_W'(1);
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign busy_o       = (state_q != IDLE);
    assign start_o      = start_q;
    assign fini_o       = fini_q;
    assign irq_o        = done_q & irq_en_q;
    assign la_data_o    = LAW'(quotient_q);
    assign hw_blinky_o  = blink_q[BLINK_W-1];
    assign sw_blinky_o  = sw_blink_q;

endmodule

// File: doc/wb_serial_divider.md
WB_SERIAL_DIVIDER -- requirements
Module: wb_serial_divider

Interface
REQ-001 Parameter WBW, default 32: Wishbone data/address width.
REQ-002 Parameter XLEN, default 32: operand width, legal 8..WBW.
REQ-003 Parameter LAW, default 32: logic-analyser output width.
REQ-004 Parameter BLINK_W, default 24: hardware blink counter width.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 reset_ni  in  1  asynchronous, active-low reset.
REQ-007 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe/cycle/write.
REQ-008 wbs_sel_i  in  WBW/8  byte selects, ignored; all writes are full-word.
REQ-009 wbs_adr_i, wbs_dat_i  in  WBW each  address, write data.
REQ-010 wbs_ack_o  out  1; wbs_dat_o  out  WBW  read data.
REQ-011 irq_o, start_o, fini_o, busy_o  out  1 each  interrupt, accept pulse, completion pulse, busy level.
REQ-012 la_data_o  out  LAW  quotient, zero-extended or truncated to LAW.
REQ-013 hw_blinky_o, sw_blinky_o  out  1 each  LED drives.

Function
REQ-014 Decode uses wbs_adr_i[4:2] only: 0 DIVIDEND RW, 1 DIVISOR RW, 2 CTRL RW, 3 STATUS R/W1C, 4 QUOTIENT RO, 5 REMAINDER RO; 6-7 read 0, writes ignored.
REQ-015 CTRL bits: [0] start (write-1 action, reads 0), [1] signed, [2] irq_en, [3] sw_blink; other bits read 0.
REQ-016 STATUS bits: [0] busy, [1] done, [2] dbz, [3] ovf; writing 1 to bit1 clears done; other STATUS bits are read-only.
REQ-017 Ack registered: wbs_ack_o high the cycle after stb&cyc is sampled with ack low, for one cycle; write side-effects occur at that sampling edge; back-to-back requests ack every other cycle.
REQ-018 Register values narrower than WBW are zero-extended on read; writes take bits [XLEN-1:0].
REQ-019 FSM states IDLE, CALC, FIX.
REQ-020 Start write in IDLE: latch operands and signed mode into working registers; clear done/dbz/ovf; assert start_o one cycle (cycle 0).
REQ-021 Start write in CALC or FIX is ignored; CTRL bits [3:1] still update; the running op keeps its latched mode.
REQ-022 DIVIDEND/DIVISOR writes during busy update registers only and do not affect the running op.
REQ-023 Normal op: CALC runs XLEN cycles of restoring division on magnitudes, 1 quotient bit per cycle; FIX runs 1 cycle and applies signs.
REQ-024 Signed results: quotient negated iff operand signs differ; remainder takes the dividend's sign; unsigned mode applies no correction.
REQ-025 Divisor 0: go straight to FIX; quotient all-ones; remainder = dividend; dbz=1.
REQ-026 Signed mode, dividend = most-negative and divisor = -1: go straight to FIX; quotient = dividend; remainder 0; ovf=1.
REQ-027 busy_o = STATUS.busy = state != IDLE: XLEN+1 cycles for a normal op, 1 cycle for special cases.
REQ-028 At FIX exit: QUOTIENT/REMAINDER update, done=1, fini_o pulses one cycle (cycle XLEN+1 normal, cycle 1 special).
REQ-029 QUOTIENT/REMAINDER hold their values until the next FIX exit.
REQ-030 Done-set and W1C in the same cycle: set wins.
REQ-031 irq_o = done & irq_en, level-sensitive, combinational from registers.
REQ-032 hw_blinky_o = MSB of a free-running BLINK_W-bit counter wrapping at all-ones; sw_blinky_o = CTRL[3].

Reset
REQ-033 On reset_ni low, immediately: all registers, counters and status bits go to 0; state goes to IDLE; every output is 0.
REQ-034 Reset asserted mid-CALC aborts the op; no fini_o pulse; results read 0 afterwards.
REQ-035 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Verification
REQ-036 XLEN=32, unsigned 100/7 -> start_o at cycle 0, busy 33 cycles, fini_o at cycle 33, Q=14, R=2, done=1.
REQ-037 Signed -7/2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> Q=0x7FFFFFFC, R=1.
REQ-038 0x1234/0 -> fini_o at cycle 1, Q=0xFFFFFFFF, R=0x1234, dbz=1; signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, ovf=1.
REQ-039 Start 100/7, rewrite DIVISOR=3 and start again at cycle 5 -> second start ignored, Q=14, R=2; next start gives 33/1.
REQ-040 irq_en=1, op completes -> irq_o=1; W1C STATUS=0x2 -> irq_o=0 next cycle; W1C coincident with fini_o -> done stays 1.
REQ-041 reset_ni low at cycle 10 of CALC -> all outputs 0 asynchronously, STATUS reads 0, no fini_o pulse.
